// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: drives all 2^N_IN vectors into a combinational DUT and waits SETTLE cycles per vector.
// It checks the sampled output against a run-time truth table and reports the error count, the first failing vector and pass/fail.
module truth_table_sweeper #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [2**N_IN-1:0]   exp_table,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 dut_out,
  output logic                 sample_strobe,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail_vec
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             mode_lat;
  logic             accept;
  logic             mismatch;

  always_comb begin
    state_nxt     = state;
    sample_strobe = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    accept        = 1'b0;
    mismatch      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (settle_cnt == CNT_LAST) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy          = 1'b1;
        sample_strobe = 1'b1;
        mismatch      = (dut_out != exp_table[vec_out]);
        // All-ones is the last vector: terminate before the increment would wrap
        if ((&vec_out) || (mode_lat && mismatch)) state_nxt = S_DONE;
        else                                      state_nxt = S_WAIT;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      vec_out        <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
      mode_lat       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        settle_cnt     <= '0;
        vec_out        <= '0;
        err_count      <= '0;
        fail_valid     <= 1'b0;
        first_fail_vec <= '0;
        pass           <= 1'b0;
        mode_lat       <= mode;
      end else if (state == S_WAIT) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else if (state == S_CHECK) begin
        if (mismatch) begin
          err_count <= err_count + 1'b1;
          if (!fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_vec <= vec_out;
          end
        end
        if (state_nxt == S_WAIT) begin
          vec_out    <= vec_out + 1'b1;
          settle_cnt <= '0;
        end else begin
          // pass is registered so it is final in the first DONE cycle
          pass <= !mismatch && (err_count == '0);
        end
      end
    end
  end

endmodule
